// File: rtl/pwm_pkg.sv
// Package shared by the PWM preconditioner and the PWM channel array.
// Contents:
//   PwmWidth    - default bit width of the cycle, counter and edge values
//   PwmDepth    - default number of transducer channels
//   edge_pair_t - one rise/fall edge pair at the default width
package pwm_pkg;

  localparam int unsigned PwmWidth = 13;
  localparam int unsigned PwmDepth = 249;

  typedef struct packed {
    logic [PwmWidth-1:0] rise;
    logic [PwmWidth-1:0] fall;
  } edge_pair_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: free-running period counter, edge registers and a registered
// compare output.
// Build option: PWM_LATCH_ON_WRAP_EN
//   defined   - new edges go to staging and become active at the channel's next wrap
//   undefined - new edges are loaded straight into the active registers
// Ports:
//   i_clk       - clock, rising edge
//   i_rst       - asynchronous active-high reset
//   i_sync      - restarts the counter at 0 (also counts as a wrap)
//   i_din_valid - i_rise/i_fall are valid this cycle
//   i_cycle     - period in clocks; below 2 holds the counter and output at 0
//   i_rise      - rising-edge time
//   i_fall      - falling-edge time
//   o_pwm       - registered PWM bit
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PwmWidth
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sync,
  input  logic             i_din_valid,
  input  logic [WIDTH-1:0] i_cycle,
  input  logic [WIDTH-1:0] i_rise,
  input  logic [WIDTH-1:0] i_fall,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_act_rise;
  logic [WIDTH-1:0] r_act_fall;
  logic             r_pwm;
  logic             w_pwm_next;
  logic             w_short;
  logic             w_last;

  assign w_short = (i_cycle < WIDTH'(2));
  assign w_last  = (r_cnt == (i_cycle - WIDTH'(1)));

  always_comb begin
    w_cnt_next = r_cnt + WIDTH'(1);
    if (i_sync || w_short || w_last) begin
      w_cnt_next = '0;
    end
  end

  // rise > fall describes a pulse that straddles the period boundary.
  always_comb begin
    w_pwm_next = 1'b0;
    if (!w_short) begin
      if (r_act_rise < r_act_fall) begin
        w_pwm_next = (r_cnt >= r_act_rise) && (r_cnt < r_act_fall);
      end else if (r_act_rise > r_act_fall) begin
        w_pwm_next = (r_cnt >= r_act_rise) || (r_cnt < r_act_fall);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_pwm <= w_pwm_next;
    end
  end

`ifdef PWM_LATCH_ON_WRAP_EN
  logic [WIDTH-1:0] r_stage_rise;
  logic [WIDTH-1:0] r_stage_fall;
  logic             r_pending;
  logic             w_wrap;

  assign w_wrap = i_sync | w_last;

  // A load coinciding with a wrap promotes the older staged pair, then stages the
  // new one, so pending stays set for the following wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stage_rise <= '0;
      r_stage_fall <= '0;
      r_pending    <= 1'b0;
      r_act_rise   <= '0;
      r_act_fall   <= '0;
    end else begin
      if (w_wrap && r_pending) begin
        r_act_rise <= r_stage_rise;
        r_act_fall <= r_stage_fall;
      end
      if (i_din_valid) begin
        r_stage_rise <= i_rise;
        r_stage_fall <= i_fall;
        r_pending    <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act_rise <= '0;
      r_act_fall <= '0;
    end else if (i_din_valid) begin
      r_act_rise <= i_rise;
      r_act_fall <= i_fall;
    end
  end
`endif

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_channel_array.sv
// Array of independent PWM channels driving the transducer outputs from the
// preconditioner's rise/fall edge tables.
// Build option: PWM_LATCH_ON_WRAP_EN (see pwm_channel) selects boundary-latched
// edge updates; undefined loads new edges immediately.
// Ports:
//   CLK       - clock, rising edge
//   RST       - asynchronous active-high reset
//   SYNC      - restarts every channel counter at 0
//   CYCLE     - per-channel period, channel i at [i*WIDTH +: WIDTH]
//   RISE      - per-channel rising-edge time
//   FALL      - per-channel falling-edge time
//   DIN_VALID - RISE/FALL valid this cycle
//   PWM_OUT   - registered PWM bit per channel
module pwm_channel_array
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PwmWidth,
  parameter int unsigned DEPTH = PwmDepth
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SYNC,
  input  logic [WIDTH*DEPTH-1:0] CYCLE,
  input  logic [WIDTH*DEPTH-1:0] RISE,
  input  logic [WIDTH*DEPTH-1:0] FALL,
  input  logic                   DIN_VALID,
  output logic [DEPTH-1:0]       PWM_OUT
);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_sync      (SYNC),
      .i_din_valid (DIN_VALID),
      .i_cycle     (CYCLE[g*WIDTH +: WIDTH]),
      .i_rise      (RISE[g*WIDTH +: WIDTH]),
      .i_fall      (FALL[g*WIDTH +: WIDTH]),
      .o_pwm       (PWM_OUT[g])
    );
  end

endmodule

// File: tb/tb_pwm_channel_array.sv
module tb_pwm_channel_array;

  localparam int unsigned W = 13;
  localparam int unsigned D = 4;

  logic             CLK;
  logic             RST;
  logic             SYNC;
  logic             DIN_VALID;
  logic [W*D-1:0]   CYCLE;
  logic [W*D-1:0]   RISE;
  logic [W*D-1:0]   FALL;
  logic [D-1:0]     PWM_OUT;

  pwm_channel_array #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SYNC      (SYNC),
    .CYCLE     (CYCLE),
    .RISE      (RISE),
    .FALL      (FALL),
    .DIN_VALID (DIN_VALID),
    .PWM_OUT   (PWM_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counter phase, active edges and expected output per channel.
  int m_cnt [D];
  int m_ar  [D];
  int m_af  [D];
  bit m_exp [D];
`ifdef PWM_LATCH_ON_WRAP_EN
  int m_sr  [D];
  int m_sf  [D];
  bit m_pend[D];
`endif

  int hc[D];

  function automatic int field(logic [W*D-1:0] v, int i);
    return int'(v[i*W +: W]);
  endfunction

  function automatic bit in_pulse(int c, int r, int f);
    if (r < f) return (c >= r) && (c < f);
    if (r > f) return (c >= r) || (c < f);
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_cnt[i] = 0;
      m_ar[i]  = 0;
      m_af[i]  = 0;
      m_exp[i] = 1'b0;
`ifdef PWM_LATCH_ON_WRAP_EN
      m_sr[i]   = 0;
      m_sf[i]   = 0;
      m_pend[i] = 1'b0;
`endif
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < D; i++) begin
      int  cyc;
      bit  wrap;
      cyc  = field(CYCLE, i);
      wrap = SYNC || (m_cnt[i] == cyc - 1);
      m_exp[i] = (cyc >= 2) && in_pulse(m_cnt[i], m_ar[i], m_af[i]);
`ifdef PWM_LATCH_ON_WRAP_EN
      if (wrap && m_pend[i]) begin
        m_ar[i] = m_sr[i];
        m_af[i] = m_sf[i];
      end
      if (DIN_VALID) begin
        m_sr[i]   = field(RISE, i);
        m_sf[i]   = field(FALL, i);
        m_pend[i] = 1'b1;
      end else if (wrap) begin
        m_pend[i] = 1'b0;
      end
`else
      if (wrap) begin
        // wrap only matters for the staged variant
      end
      if (DIN_VALID) begin
        m_ar[i] = field(RISE, i);
        m_af[i] = field(FALL, i);
      end
`endif
      m_cnt[i] = (SYNC || cyc < 2) ? 0 : (m_cnt[i] + 1) % cyc;
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      if (!RST) model_step();
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      logic [D-1:0] exp_v;
      @(negedge CLK);
      for (int i = 0; i < D; i++) exp_v[i] = m_exp[i];
      n_tests++;
      if (PWM_OUT !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t: PWM_OUT=%b expected %b", $time, PWM_OUT, exp_v);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(int i, int cyc, int r, int f);
    CYCLE[i*W +: W] = W'(cyc);
    RISE[i*W +: W]  = W'(r);
    FALL[i*W +: W]  = W'(f);
  endtask

  task automatic pulse_din();
    DIN_VALID = 1'b1;
    step();
    DIN_VALID = 1'b0;
  endtask

  task automatic count_high(int n);
    for (int i = 0; i < D; i++) hc[i] = 0;
    repeat (n) begin
      step();
      for (int i = 0; i < D; i++) if (PWM_OUT[i]) hc[i]++;
    end
  endtask

  task automatic wait_cnt(int ch, int val);
    int k;
    k = 0;
    while (m_cnt[ch] != val && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) check("wait_cnt_timeout", m_cnt[ch], val);
  endtask

  initial begin
    RST       = 1'b1;
    SYNC      = 1'b0;
    DIN_VALID = 1'b0;
    CYCLE     = '0;
    RISE      = '0;
    FALL      = '0;
    model_reset();
    #12;
    check("reset_pwm", int'(PWM_OUT), 0);
    #10;
    RST = 1'b0;
    step();

    // Basic pulse, independent periods, equal edges, single-clock period.
    set_ch(0, 10, 2, 5);
    set_ch(1, 7, 2, 5);
    set_ch(2, 10, 3, 3);
    set_ch(3, 1, 2, 5);
    SYNC      = 1'b1;
    DIN_VALID = 1'b1;
    step();
    SYNC      = 1'b0;
    DIN_VALID = 1'b0;
    repeat (25) step();
    count_high(21);
    check("cycle7_duty", hc[1], 9);
    check("equal_edges_low", hc[2], 0);
    check("cycle1_low", hc[3], 0);
    count_high(20);
    check("basic_duty", hc[0], 6);

    // Wrapped pulse.
    set_ch(0, 10, 8, 3);
    pulse_din();
    repeat (25) step();
    count_high(20);
    check("wrapped_duty", hc[0], 10);

    // Boundary latching: new edges issued at cnt = 4 under (2,5).
    set_ch(0, 10, 2, 5);
    pulse_din();
    repeat (25) step();
    wait_cnt(0, 4);
    set_ch(0, 10, 1, 8);
    pulse_din();
    count_high(5);
`ifdef PWM_LATCH_ON_WRAP_EN
    check("boundary_rest_of_period", hc[0], 0);
`else
    check("boundary_rest_of_period", hc[0], 3);
`endif
    count_high(10);
    check("boundary_next_period", hc[0], 7);

    // DIN_VALID on the wrap cycle with nothing pending.
    wait_cnt(0, 9);
    set_ch(0, 10, 2, 5);
    pulse_din();
    count_high(10);
`ifdef PWM_LATCH_ON_WRAP_EN
    check("simul_next_period", hc[0], 7);
`else
    check("simul_next_period", hc[0], 3);
`endif
    count_high(10);
    check("simul_following_period", hc[0], 3);

    // Reset mid-period with an update pending and the output high.
    wait_cnt(0, 3);
    check("pre_reset_high", int'(PWM_OUT[0]), 1);
    set_ch(0, 10, 6, 9);
    pulse_din();
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check("async_reset_pwm", int'(PWM_OUT), 0);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    count_high(20);
    check("no_stale_update_ch0", hc[0], 0);
    check("no_stale_update_ch1", hc[1], 0);

    // Randomized traffic.
    repeat (600) begin
      bit do_sync;
      do_sync = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < D; i++) CYCLE[i*W +: W] = W'($urandom_range(0, 14));
        do_sync = 1'b1;
      end
      SYNC      = do_sync;
      DIN_VALID = ($urandom_range(0, 7) == 0);
      if (DIN_VALID) begin
        for (int i = 0; i < D; i++) begin
          int cyc;
          cyc = field(CYCLE, i);
          RISE[i*W +: W] = W'($urandom_range(0, cyc + 1));
          FALL[i*W +: W] = W'($urandom_range(0, cyc + 1));
        end
      end
      step();
    end
    SYNC      = 1'b0;
    DIN_VALID = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
